// File: rtl/fifo_pop_stream_if.sv
// Handshake bundle between the upstream synchronous FIFO, fifo_pop_stream and the downstream stream.
// The master modport is the fifo_pop_stream side and the slave modport is the environment side.
interface fifo_pop_stream_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  fifo_empty_in;
   logic [DATA_WIDTH-1:0] fifo_data_in;
   logic                  fifo_pop_req_out;
   logic                  m_valid_out;
   logic                  m_ready_in;
   logic [DATA_WIDTH-1:0] m_data_out;

   modport master (
      input  fifo_empty_in,
      input  fifo_data_in,
      input  m_ready_in,
      output fifo_pop_req_out,
      output m_valid_out,
      output m_data_out
   );

   modport slave (
      output fifo_empty_in,
      output fifo_data_in,
      output m_ready_in,
      input  fifo_pop_req_out,
      input  m_valid_out,
      input  m_data_out
   );
endinterface

// File: rtl/fifo_pop_stream.sv
// Turns a synchronous FIFO into a valid/ready stream through a 2-entry skid buffer (head E0, skid E1).
// Optional transfer counter on xfer_cnt_out is enabled by the macro FIFO_POP_STREAM_XFER_CNT_EN.
module fifo_pop_stream #(
   parameter int DATA_WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   fifo_pop_stream_if.master  bus
`ifdef FIFO_POP_STREAM_XFER_CNT_EN
   ,
   output logic [31:0]        xfer_cnt_out
`endif
);

   typedef enum logic [1:0] {
      OCC_0 = 2'd0,
      OCC_1 = 2'd1,
      OCC_2 = 2'd2
   } occ_t;

   occ_t                  occ_reg;
   occ_t                  occ_next;
   logic [DATA_WIDTH-1:0] e0_reg;
   logic [DATA_WIDTH-1:0] e0_next;
   logic [DATA_WIDTH-1:0] e1_reg;
   logic [DATA_WIDTH-1:0] e1_next;
   logic                  pop;
   logic                  fire;

   // Pop depends only on FIFO state and occupancy, so ready never reaches the FIFO combinationally.
   assign pop  = ~bus.fifo_empty_in && (occ_reg != OCC_2) && ~rst;
   assign fire = (occ_reg != OCC_0) && bus.m_ready_in;

   always_comb begin
      occ_next = occ_reg;
      e0_next  = e0_reg;
      e1_next  = e1_reg;
      case (occ_reg)
         OCC_0: begin
            if (pop) begin
               e0_next  = bus.fifo_data_in;
               occ_next = OCC_1;
            end
         end
         OCC_1: begin
            if (pop && !fire) begin
               e1_next  = bus.fifo_data_in;
               occ_next = OCC_2;
            end else if (pop && fire) begin
               e0_next  = bus.fifo_data_in;
            end else if (fire) begin
               occ_next = OCC_0;
            end
         end
         OCC_2: begin
            if (fire) begin
               e0_next  = e1_reg;
               occ_next = OCC_1;
            end
         end
         default: begin
            occ_next = OCC_0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_reg <= OCC_0;
         e0_reg  <= '0;
         e1_reg  <= '0;
      end else begin
         occ_reg <= occ_next;
         e0_reg  <= e0_next;
         e1_reg  <= e1_next;
      end
   end

   assign bus.fifo_pop_req_out = pop;
   assign bus.m_valid_out      = (occ_reg != OCC_0);
   assign bus.m_data_out       = e0_reg;

`ifdef FIFO_POP_STREAM_XFER_CNT_EN
   logic [31:0] xfer_cnt_reg;

   // Natural 32-bit wrap from all-ones to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt_reg <= '0;
      end else if (fire) begin
         xfer_cnt_reg <= xfer_cnt_reg + 32'd1;
      end
   end

   assign xfer_cnt_out = xfer_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed and random checks of fifo_pop_stream against an upstream FIFO model and an output scoreboard.
module tb_fifo_pop_stream;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_pop_stream_if #(.DATA_WIDTH(DW)) ifc ();

`ifdef FIFO_POP_STREAM_XFER_CNT_EN
   logic [31:0] xfer_cnt;
`endif

   fifo_pop_stream #(.DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (ifc.master)
`ifdef FIFO_POP_STREAM_XFER_CNT_EN
      ,
      .xfer_cnt_out (xfer_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] sb[$];
   logic [DW-1:0] out_log[$];
   int            fire_log[$];
   int            pop_log[$];
   logic          pop_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: samples at the falling edge what the next rising edge will act on.
   always @(negedge clk) begin
      pop_seen = ifc.fifo_pop_req_out;
      if (ifc.fifo_empty_in)
         check("pop_while_empty", {31'd0, ifc.fifo_pop_req_out}, 32'd0);
      if (rst) begin
         sb.delete();
      end else begin
         if (ifc.m_valid_out && ifc.m_ready_in) begin
            if (sb.size() == 0) begin
               check("unexpected_output", 32'd1, 32'd0);
            end else begin
               check("sb_data", {16'd0, ifc.m_data_out}, {16'd0, sb.pop_front()});
            end
            out_log.push_back(ifc.m_data_out);
            fire_log.push_back(cyc);
            $display("[TB] cyc %0d out 0x%0h", cyc, ifc.m_data_out);
         end
         if (ifc.fifo_pop_req_out) begin
            sb.push_back(ifc.fifo_data_in);
            pop_log.push_back(cyc);
         end
      end
      cyc++;
   end

   task automatic refresh();
      ifc.fifo_empty_in = (fifo_q.size() == 0);
      ifc.fifo_data_in  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
      refresh();
   endtask

   task automatic clear_logs();
      out_log.delete();
      fire_log.delete();
      pop_log.delete();
   endtask

   task automatic run_until_idle(input string name, input int max);
      int n = 0;
      while ((fifo_q.size() != 0 || ifc.m_valid_out) && n < max) begin
         tick();
         n++;
      end
      check({name, "_timeout"}, {31'd0, (n < max)}, 32'd1);
   endtask

   task automatic check_log(input string name, input logic [DW-1:0] exp[$]);
      int bad = 0;
      check({name, "_count"}, out_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < out_log.size(); i++)
         if (out_log[i] !== exp[i]) bad++;
      check({name, "_order"}, bad, 0);
   endtask

   task automatic check_back_to_back(input string name);
      int bad = 0;
      for (int i = 0; i < fire_log.size(); i++)
         if (fire_log[i] != fire_log[0] + i) bad++;
      check({name, "_no_gap"}, bad, 0);
   endtask

   initial begin
      logic [DW-1:0] exp_q[$];
      int sent;
      int n;

      rst = 1'b1;
      ifc.m_ready_in = 1'b0;
      refresh();
      repeat (3) tick();
      rst = 1'b0;
      check("rst_pop_req", {31'd0, ifc.fifo_pop_req_out}, 32'd0);
      check("rst_valid",   {31'd0, ifc.m_valid_out}, 32'd0);
      check("rst_data",    {16'd0, ifc.m_data_out}, 32'd0);

      // Empty FIFO with ready high: nothing moves.
      ifc.m_ready_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_pop_req", {31'd0, ifc.fifo_pop_req_out}, 32'd0);
         check("idle_valid",   {31'd0, ifc.m_valid_out}, 32'd0);
         check("idle_data",    {16'd0, ifc.m_data_out}, 32'd0);
      end

      // Streaming 0x0001..0x0008 with ready held high.
      clear_logs();
      exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
      foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
      refresh();
      run_until_idle("stream8", 40);
      check("stream8_pops", pop_log.size(), 8);
      check_log("stream8", exp_q);
      if (pop_log.size() > 0 && fire_log.size() > 0)
         check("stream8_latency", fire_log[0], pop_log[0] + 1);
      else
         check("stream8_latency", 32'd0, 32'd1);
      check_back_to_back("stream8");
      check("stream8_valid_drop", {31'd0, ifc.m_valid_out}, 32'd0);

      // Backpressure: buffer fills to two and head stays stable.
      clear_logs();
      ifc.m_ready_in = 1'b0;
      exp_q = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5};
      foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
      refresh();
      for (int i = 0; i < 6; i++) begin
         tick();
         check("bp_valid", {31'd0, ifc.m_valid_out}, 32'd1);
         check("bp_data_stable", {16'd0, ifc.m_data_out}, 32'h00A0);
      end
      check("bp_pops", pop_log.size(), 2);
      check("bp_full_no_pop", {31'd0, ifc.fifo_pop_req_out}, 32'd0);
      ifc.m_ready_in = 1'b1;
      run_until_idle("bp_drain", 40);
      check_log("bp_drain", exp_q);
      check_back_to_back("bp_drain");

      // Random ready and random FIFO refill with 1000 words.
      clear_logs();
      exp_q.delete();
      sent = 0;
      n = 0;
      while ((sent < 1000 || fifo_q.size() != 0 || ifc.m_valid_out) && n < 8000) begin
         if (sent < 1000 && $urandom_range(0, 1) == 1) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            fifo_q.push_back(w);
            exp_q.push_back(w);
            sent++;
         end
         ifc.m_ready_in = ($urandom_range(0, 1) == 1);
         refresh();
         tick();
         n++;
      end
      check("rand_timeout", {31'd0, (n < 8000)}, 32'd1);
      check_log("rand", exp_q);

      // Reset while full discards both buffered words.
      clear_logs();
      ifc.m_ready_in = 1'b0;
      fifo_q = '{16'h00B0, 16'h00B1, 16'h00B2, 16'h00B3};
      refresh();
      repeat (4) tick();
      check("prerst_full", {31'd0, ifc.fifo_pop_req_out}, 32'd0);
      rst = 1'b1;
      #1;
      check("rst_blocks_pop", {31'd0, ifc.fifo_pop_req_out}, 32'd0);
      tick();
      rst = 1'b0;
      check("postrst_valid", {31'd0, ifc.m_valid_out}, 32'd0);
      check("postrst_data",  {16'd0, ifc.m_data_out}, 32'd0);
      clear_logs();
      fifo_q.delete();
      exp_q = '{16'h00C0, 16'h00C1, 16'h00C2};
      foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
      ifc.m_ready_in = 1'b1;
      refresh();
      run_until_idle("postrst", 40);
      check_log("postrst", exp_q);

`ifdef FIFO_POP_STREAM_XFER_CNT_EN
      begin
         logic [31:0] cnt_exp[3];
         int k;
         cnt_exp = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
         clear_logs();
         force dut.xfer_cnt_reg = 32'hFFFF_FFFE;
         tick();
         release dut.xfer_cnt_reg;
         fifo_q = '{16'h00D0, 16'h00D1, 16'h00D2};
         refresh();
         k = 0;
         n = 0;
         while (k < 3 && n < 40) begin
            tick();
            n++;
            if (fire_log.size() > k) begin
               check("xfer_cnt", xfer_cnt, cnt_exp[k]);
               k++;
            end
         end
         check("xfer_cnt_timeout", k, 3);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_pop_stream.md
FIFO_POP_STREAM -- requirements
Module: fifo_pop_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of every data port.
REQ-002 clk  input  1  SHALL be the single clock; every register updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 fifo_empty_in  input  1  SHALL carry the empty flag of the upstream synchronous FIFO.
REQ-005 fifo_data_in  input  DATA_WIDTH  SHALL carry the upstream FIFO head word, valid in the same cycle as a pop.
REQ-006 fifo_pop_req_out  output  1  SHALL be the pop request to the upstream FIFO; one pop SHALL occur per high cycle.
REQ-007 m_valid_out  output  1  SHALL be the downstream stream valid.
REQ-008 m_ready_in  input  1  SHALL be the downstream stream ready.
REQ-009 m_data_out  output  DATA_WIDTH  SHALL be the downstream stream data.
REQ-010 xfer_cnt_out  output  32  SHALL be the transfer count, present only per REQ-027.

Function
REQ-011 The block SHALL hold a 2-entry buffer: head entry E0 drives m_data_out; skid entry E1; occupancy OCC is 0, 1 or 2.
REQ-012 m_valid_out SHALL be high exactly when OCC != 0, driven from a register or a decode of OCC only.
REQ-013 fifo_pop_req_out SHALL equal (~fifo_empty_in && OCC != 2 && ~rst), with no combinational path from m_ready_in.
REQ-014 A pop SHALL never be issued while fifo_empty_in is high, so the upstream error flag is never set by this block.
REQ-015 A transfer (fire) SHALL occur on a cycle with m_valid_out && m_ready_in.
REQ-016 OCC=0 with pop: E0 <= fifo_data_in, OCC <= 1.
REQ-017 OCC=1 with pop, no fire: E1 <= fifo_data_in, OCC <= 2.
REQ-018 OCC=1 with pop and fire: E0 <= fifo_data_in, OCC stays 1.
REQ-019 OCC=1 with fire, no pop: OCC <= 0; E0 holds its value.
REQ-020 OCC=2 with fire: E0 <= E1, OCC <= 1; no pop is possible in this state.
REQ-021 Any state with neither pop nor fire: all state SHALL hold.
REQ-022 Latency: a word popped in cycle t SHALL appear on m_data_out with m_valid_out high in cycle t+1.
REQ-023 Throughput: with the FIFO non-empty and m_ready_in held high, one word SHALL transfer per cycle after the first.
REQ-024 While m_valid_out && ~m_ready_in, m_data_out SHALL stay stable, and words SHALL be delivered in pop order with no loss or duplication.

Reset
REQ-025 On rst high at a rising edge: OCC <= 0, E0 <= 0, E1 <= 0, m_valid_out <= 0, m_data_out <= 0, xfer_cnt_out <= 0.
REQ-026 Reset mid-operation SHALL discard buffered words; fifo_pop_req_out SHALL be 0 in every cycle rst is high.

Configuration
REQ-027 When macro FIFO_POP_STREAM_XFER_CNT_EN is defined, xfer_cnt_out SHALL exist and increment by 1 on each fire, wrapping from 32'hFFFF_FFFF to 0.
REQ-028 When FIFO_POP_STREAM_XFER_CNT_EN is undefined, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Reset, FIFO empty, m_ready_in=1 for 10 cycles -> fifo_pop_req_out=0, m_valid_out=0, m_data_out=0 throughout.
REQ-030 FIFO holds 0x0001..0x0008, m_ready_in=1 -> 8 pops; m_data_out 0x0001..0x0008 on consecutive cycles, the first one cycle after the first pop; m_valid_out then drops.
REQ-031 FIFO holds 0xA0..0xA5, m_ready_in=0 -> exactly 2 pops; OCC=2; m_data_out=0xA0 stable; ready then high -> 0xA0..0xA5 in order with no gap after the first.
REQ-032 m_ready_in random at 50% with 1000 random words -> output sequence equals input sequence, and fifo_pop_req_out is never high while fifo_empty_in is high.
REQ-033 rst pulsed for 1 cycle while OCC=2 -> next cycle m_valid_out=0 and OCC=0; old words are never emitted; new words flow normally.
REQ-034 FIFO_POP_STREAM_XFER_CNT_EN defined, counter preloaded via force to 0xFFFF_FFFE, 3 fires -> xfer_cnt_out reads 0xFFFF_FFFF, 0x0, 0x1.
